l2_arbiter: RTL
===============

// Module: l2_arbiter
// PURPOSE
//  Two-port arbiter between the L1 I-cache and L1 D-cache physical-memory sides and the single L2/pmem port.
//  Each L1 holds pmem_read/pmem_write plus address/wdata stable until its pmem_resp.
//  The arbiter grants one L1 at a time and forwards the transaction to L2.
//  It routes l2_resp back to the owner only.
// PARAMETERS
//  ADDR_WIDTH  16   byte address width of line requests
//  LINE_WIDTH  128  cache line width (bits) on wdata/rdata
// PORTS
//  clk             in   1           single clock; all state on posedge clk
//  reset_n         in   1           reset, asynchronous, active-low
//  i_pmem_read     in   1           I-cache line read request
//  i_pmem_address  in   ADDR_WIDTH  I-cache line address
//  i_pmem_rdata    out  LINE_WIDTH  line data to I-cache
//  i_pmem_resp     out  1           I-cache transaction done
//  d_pmem_read     in   1           D-cache line read request
//  d_pmem_write    in   1           D-cache writeback request
//  d_pmem_address  in   ADDR_WIDTH  D-cache line address
//  d_pmem_wdata    in   LINE_WIDTH  D-cache writeback data
//  d_pmem_rdata    out  LINE_WIDTH  line data to D-cache
//  d_pmem_resp     out  1           D-cache transaction done
//  l2_read         out  1           L2 read request
//  l2_write        out  1           L2 write request
//  l2_address      out  ADDR_WIDTH  L2 line address
//  l2_wdata        out  LINE_WIDTH  L2 write data
//  l2_rdata        in   LINE_WIDTH  L2 read data
//  l2_resp         in   1           L2 transaction done (1-cycle pulse)
// BEHAVIOUR
//  States: IDLE, GRANT_I, GRANT_D. Registered last_served flag (I/D).
//  Reset (async, reset_n=0) forces:
//   - state=IDLE, last_served=I
//   - l2_read=l2_write=0, i_pmem_resp=d_pmem_resp=0
//  Arbitration:
//   - IDLE drives no L2 request.
//   - A request seen in cycle N gives GRANT_x at N+1, with the L2 request visible in N+1 (+1 cycle per miss).
//   - Both I and D pending in IDLE: priority per CONFIGURATION.
//  Request forwarding (combinational from state):
//   - GRANT_I: l2_read=i_pmem_read, l2_write=0, l2_address=i_pmem_address.
//   - GRANT_D: l2_read=d_pmem_read&~d_pmem_write, l2_write=d_pmem_write, l2_address=d_pmem_address.
//   - l2_wdata=d_pmem_wdata always.
//  Response routing:
//   - i_pmem_rdata=d_pmem_rdata=l2_rdata (broadcast).
//   - i_pmem_resp=(state==GRANT_I)&l2_resp; d_pmem_resp=(state==GRANT_D)&l2_resp.
//  State transitions:
//   - GRANT_x with l2_resp=1: next=IDLE, last_served=x.
//   - GRANT_x with the owner dropping all requests before l2_resp (abort): next=IDLE, last_served unchanged.
//  D-cache read+write asserted together: write wins.
//  Writeback then refill from D: write_block to resp, IDLE for one cycle, then a fresh arbitration; I may win it.
//  l2_resp while IDLE: ignored, no resp to either L1.
//  Reset mid-transaction: the L2 request drops asynchronously; the L1s are reset by the same reset_n.
// CONFIGURATION
//  L2_ARB_RR_EN defined: round-robin.
//   - On a tie, grant the requester != last_served.
//   - First tie after reset goes to D.
//  L2_ARB_RR_EN undefined: fixed priority.
//   - D always wins a tie.
//   - last_served is still kept but unused for arbitration.
// STRUCTURE
//  Package lc3b_types gains:
//   - lc3b_pmem_line (logic [127:0])
//   - typedef enum l2_arb_state_t {IDLE, GRANT_I, GRANT_D}
//   - typedef enum l2_arb_owner_t {OWNER_I, OWNER_D}
//  No sub-module; the grant select is a single always_comb.
// TESTING
//  1. I-only: i_pmem_read=1, addr 16'h1230; l2_resp after 3 cycles.
//     -> l2_read=1 from the next cycle, l2_address=16'h1230, i_pmem_resp on the resp cycle, d_pmem_resp=0.
//  2. D writeback: d_pmem_write=1, addr 16'h4440, wdata=128'hA5..A5.
//     -> l2_write=1, l2_wdata matches, d_pmem_resp pulses once, then IDLE.
//  3. Tie, macro undefined: i and d both read in the same cycle, three back-to-back times.
//     -> D granted every time; I served only after D releases.
//  4. Tie, L2_ARB_RR_EN defined: repeated simultaneous requests.
//     -> grants alternate D,I,D,I starting with D after reset.
//  5. reset_n=0 asserted mid GRANT_D with l2_write=1.
//     -> l2_write drops without a clock edge; state IDLE; next tie goes to D.
//  6. Stray l2_resp=1 in IDLE, and D read+write both high.
//     -> no L1 resp for the stray; l2_write=1, l2_read=0 for the dual request.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: pmem line and the L2 arbiter state/owner encodings.
package lc3b_types;

    localparam int PMEM_ADDR_WIDTH = 16;
    localparam int PMEM_LINE_WIDTH = 128;

    typedef logic [127:0] lc3b_pmem_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } l2_arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } l2_arb_owner_t;

endpackage

// File: rtl/l2_arbiter.sv
// Arbitrates the L1 I-cache and D-cache pmem sides onto the single L2 port, one owner at a time.
// Build option L2_ARB_RR_EN: round-robin on ties; otherwise the D-cache always wins a tie.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  l2_read,
    output logic                  l2_write,
    output logic [ADDR_WIDTH-1:0] l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    l2_arb_state_t r_state;
    l2_arb_state_t w_state_nxt;
    l2_arb_owner_t r_last;
    l2_arb_owner_t w_last_nxt;
    logic          w_i_req;
    logic          w_d_req;

    assign w_i_req      = i_pmem_read;
    assign w_d_req      = d_pmem_read | d_pmem_write;
    assign l2_wdata     = d_pmem_wdata;
    assign i_pmem_rdata = l2_rdata;
    assign d_pmem_rdata = l2_rdata;

    // State and last-served registers; reset drops any L2 request immediately via r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= OWNER_I;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Grant select, request forwarding to L2 and response routing to the owner.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        l2_read     = 1'b0;
        l2_write    = 1'b0;
        l2_address  = {ADDR_WIDTH{1'b0}};
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
`ifdef L2_ARB_RR_EN
                    w_state_nxt = (r_last == OWNER_I) ? GRANT_D : GRANT_I;
`else
                    w_state_nxt = GRANT_D;
`endif
                end else if (w_d_req) begin
                    w_state_nxt = GRANT_D;
                end else if (w_i_req) begin
                    w_state_nxt = GRANT_I;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GRANT_I: begin
                l2_read     = i_pmem_read;
                l2_address  = i_pmem_address;
                i_pmem_resp = l2_resp;
                if (l2_resp) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = OWNER_I;
                end else if (!w_i_req) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GRANT_I;
                end
            end
            GRANT_D: begin
                // A writeback always beats a simultaneous refill from the same cache.
                l2_read     = d_pmem_read & ~d_pmem_write;
                l2_write    = d_pmem_write;
                l2_address  = d_pmem_address;
                d_pmem_resp = l2_resp;
                if (l2_resp) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = OWNER_D;
                end else if (!w_d_req) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GRANT_D;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
